// File: rtl/db_timer_arbiter_if.sv
// -----------------------------------------------------------------------------
// db_timer_arbiter_if
//   Signal bundle between the front-panel switch inputs and the shared-timer
//   debouncer.
//
//   Parameters
//     CH   number of input channels
//     IDW  width of grant_id, max(1, clog2(CH))
//
//   Signals
//     sw        raw asynchronous switch inputs            (master -> slave)
//     db_level  debounced level per channel               (slave -> master)
//     db_tick   1-cycle pulse, debounced level rose       (slave -> master)
//     db_fall   1-cycle pulse, debounced level fell       (slave -> master)
//     busy      shared timer currently granted            (slave -> master)
//     grant_id  index of the granted / last-granted chan  (slave -> master)
//
//   Modports
//     master  the side that presents the switches and consumes the results
//     slave   the debouncer itself
// -----------------------------------------------------------------------------
interface db_timer_arbiter_if #(
  parameter int unsigned CH = 4
);
  localparam int unsigned IDW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]  sw;
  logic [CH-1:0]  db_level;
  logic [CH-1:0]  db_tick;
  logic [CH-1:0]  db_fall;
  logic           busy;
  logic [IDW-1:0] grant_id;

  modport master (
    output sw,
    input  db_level,
    input  db_tick,
    input  db_fall,
    input  busy,
    input  grant_id
  );

  modport slave (
    input  sw,
    output db_level,
    output db_tick,
    output db_fall,
    output busy,
    output grant_id
  );
endinterface

// File: rtl/db_timer_arbiter.sv
// -----------------------------------------------------------------------------
// db_timer_arbiter
//   Debounces CH raw switch/button inputs with a single shared N-bit timer.
//   A round-robin arbiter hands the timer to one channel whose synchronised
//   input disagrees with its debounced level; that channel's change is then
//   qualified for 2^N cycles before its debounced level flips.
//
//   Parameters
//     CH  number of input channels (>= 1)
//     N   timer width; qualification time is 2^N clk cycles
//
//   Ports
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      slave modport of db_timer_arbiter_if:
//                sw (in), db_level / db_tick / db_fall / busy / grant_id (out)
//
//   All outputs are registered. grant_id holds its last value while idle.
// -----------------------------------------------------------------------------
module db_timer_arbiter #(
  parameter int unsigned CH = 4,
  parameter int unsigned N  = 21
) (
  input  logic               clk,
  input  logic               reset_n,
  db_timer_arbiter_if.slave  bus
);

  localparam int unsigned IDW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e          state_q, state_d;

  // two-flop synchronizer; sync2_q is the synchronised input sw_s
  logic [CH-1:0]   sync1_q;
  logic [CH-1:0]   sync2_q;

  logic [CH-1:0]   level_q, level_d;
  logic [CH-1:0]   tick_q,  tick_d;
  logic [CH-1:0]   fall_q,  fall_d;
  logic            busy_q,  busy_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [N-1:0]    timer_q, timer_d;

  logic [CH-1:0]   req;
  logic [IDW-1:0]  pick;

  // First requesting channel searching last+1, last+2, ... modulo CH, so the
  // most recently served channel has lowest priority.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [CH-1:0]  r,
    input logic [IDW-1:0] last
  );
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= CH; k++) begin
      idx = 32'(last) + k;
      if (idx >= CH) begin
        idx = idx - CH;
      end
      if (!found && r[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.sw;
      sync2_q <= sync1_q;
    end
  end

  // A channel requests the timer whenever its synchronised input differs
  // from its debounced level.
  always_comb begin
    req  = sync2_q ^ level_q;
    pick = rr_pick(req, last_q);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      level_q <= '0;
      tick_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      last_q  <= IDW'(CH - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter / qualification FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tick_d  = '0;
    fall_d  = '0;
    busy_d  = busy_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          last_d  = pick;
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!req[grant_q]) begin
          // input went back to the debounced level: drop the grant silently
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_q == '1) begin
          level_d[grant_q] = ~level_q[grant_q];
          if (!level_q[grant_q]) begin
            tick_d[grant_q] = 1'b1;
          end else begin
            fall_d[grant_q] = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.db_level = level_q;
  assign bus.db_tick  = tick_q;
  assign bus.db_fall  = fall_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_db_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_db_timer_arbiter
//   Scoreboard bench for db_timer_arbiter with CH=4, N=4 (2^N = 16).
//   A behavioural model predicts the outputs of every cycle and queues them;
//   a monitor on the falling edge pops and compares. Directed sequences add
//   latency, bounce, ordering and fairness checks; a random phase follows.
// -----------------------------------------------------------------------------
module tb_db_timer_arbiter;
  localparam int CH = 4;
  localparam int N  = 4;
  localparam int QT = 1 << N;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  db_timer_arbiter_if #(.CH(CH)) bus ();

  db_timer_arbiter #(.CH(CH), .N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] level;
    logic [CH-1:0] tick;
    logic [CH-1:0] fall;
    logic          busy;
    int            gid;
  } snap_t;

  snap_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model: inputs reach the logic after a 2-deep delay line; the
  // timer belongs to at most one owner, which must keep disagreeing with its
  // debounced level for QT cycles after the grant before the level flips.
  // ---------------------------------------------------------------------------
  bit [CH-1:0] m_s1, m_s2, m_level;
  int          m_owner, m_last, m_gid, m_age;

  always @(posedge clk) begin
    snap_t       s;
    bit [CH-1:0] rq, tk, fl;
    int          c;
    tk = '0;
    fl = '0;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_owner = -1; m_last = CH - 1; m_gid = 0; m_age = 0;
    end else begin
      rq = m_s2 ^ m_level;
      if (m_owner < 0) begin
        for (int k = 1; k <= CH; k++) begin
          c = (m_last + k) % CH;
          if (m_owner < 0 && rq[c]) begin
            m_owner = c; m_last = c; m_gid = c; m_age = 0;
          end
        end
      end else if (!rq[m_owner]) begin
        m_owner = -1;
      end else begin
        m_age++;
        if (m_age == QT) begin
          m_level[m_owner] = ~m_level[m_owner];
          if (m_level[m_owner]) tk[m_owner] = 1'b1;
          else                  fl[m_owner] = 1'b1;
          m_owner = -1;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.sw;
    end
    s.level = m_level;
    s.tick  = tk;
    s.fall  = fl;
    s.busy  = (m_owner >= 0);
    s.gid   = m_gid;
    exp_q.push_back(s);
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.db_level !== e.level || bus.db_tick !== e.tick ||
          bus.db_fall !== e.fall || bus.busy !== e.busy ||
          int'(bus.grant_id) !== e.gid) begin
        errors++;
        $display("FAIL cycle_snapshot t=%0t: got lvl=%b tick=%b fall=%b busy=%b gid=%0d expected lvl=%b tick=%b fall=%b busy=%b gid=%0d",
                 $time, bus.db_level, bus.db_tick, bus.db_fall, bus.busy, bus.grant_id,
                 e.level, e.tick, e.fall, e.busy, e.gid);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] v);
    @(negedge clk);
    #1;
    bus.sw = v;
  endtask

  // Count falling edges until the selected pulse is seen; -1 if it never is.
  task automatic wait_ev(input int ch, input bit rise, input int maxc, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < maxc) begin
      @(negedge clk);
      n++;
      hit = rise ? (bus.db_tick[ch] === 1'b1) : (bus.db_fall[ch] === 1'b1);
    end
    if (!hit) n = -1;
  endtask

  function automatic int all_outs();
    return int'({bus.db_level, bus.db_tick, bus.db_fall, bus.busy, bus.grant_id});
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          n;
    int          order[$];
    bit          saw_busy;
    int          tick0;
    logic [31:0] r;
    int          hold;

    bus.sw = '1;

    // reset held with all switches high
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs_zero", all_outs(), 0);
    end
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("first_grant_busy_c%0d", i), int'(bus.busy), (i == 3) ? 1 : 0);
    end
    chk("first_grant_id", int'(bus.grant_id), 0);

    // all four channels qualify in round-robin order, 17 cycles apart
    wait_ev(0, 1'b1, 40, n); chk("tick0_after_grant", n, QT);
    wait_ev(1, 1'b1, 40, n); chk("tick1_spacing", n, QT + 1);
    wait_ev(2, 1'b1, 40, n); chk("tick2_spacing", n, QT + 1);
    wait_ev(3, 1'b1, 40, n); chk("tick3_spacing", n, QT + 1);
    chk("all_levels_high", int'(bus.db_level), 15);
    drive('0);
    repeat (100) @(negedge clk);
    chk("all_levels_low", int'(bus.db_level), 0);

    // single rising then falling edge on ch2
    drive(4'b0100);
    wait_ev(2, 1'b1, 60, n);
    chk("ch2_rise_latency", n, QT + 3);
    chk("ch2_level_high", int'(bus.db_level[2]), 1);
    repeat (5) @(negedge clk);
    drive(4'b0000);
    wait_ev(2, 1'b0, 60, n);
    chk("ch2_fall_latency", n, QT + 3);
    chk("ch2_level_low", int'(bus.db_level[2]), 0);
    repeat (10) @(negedge clk);

    // bounce on ch0: 8 cycles high is too short to qualify
    drive(4'b0001);
    saw_busy = 1'b0;
    tick0    = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
      if (bus.db_tick[0]) tick0++;
    end
    #1 bus.sw = '0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
      if (bus.db_tick[0]) tick0++;
    end
    chk("bounce_busy_seen", int'(saw_busy), 1);
    chk("bounce_no_tick", tick0, 0);
    chk("bounce_level_low", int'(bus.db_level[0]), 0);
    chk("bounce_idle_after", int'(bus.busy), 0);

    // fairness: ch1 served last, so ch2 beats ch0 when both arrive together
    drive(4'b0010);
    wait_ev(1, 1'b1, 60, n);
    chk("ch1_rise_latency", n, QT + 3);
    #1 bus.sw = 4'b0111;
    n = 0;
    while (order.size() < 2 && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.db_tick[0]) order.push_back(0);
      if (bus.db_tick[2]) order.push_back(2);
    end
    chk("fair_first", (order.size() > 0) ? order[0] : -1, 2);
    chk("fair_second", (order.size() > 1) ? order[1] : -1, 0);
    drive('0);
    repeat (100) @(negedge clk);

    // reset in the middle of a qualification
    drive(4'b1000);
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ch3_granted", int'(bus.busy), 1);
    repeat (9) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("midcount_reset_clears", all_outs(), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_ev(3, 1'b1, 60, n);
    chk("requalify_after_reset", n, QT + 3);

    // random phase: mix of bounces and held changes, occasional reset
    drive('0);
    repeat (80) @(negedge clk);
    for (int it = 0; it < 150; it++) begin
      r    = $urandom;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12))
                                         : int'($urandom_range(18, 60));
      drive(r[CH-1:0]);
      repeat (hold - 1) @(negedge clk);
      if ($urandom_range(0, 40) == 0) begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
